// File: rtl/volleyball_set_ctrl.sv
// Set/match controller: awards sets on rising set-won flags, holds the final score, then pulses point reset.
// Optional SET_UNDO_EN adds an undo_set input that reverts the most recent award.
module volleyball_set_ctrl #(
    parameter int SETS_TO_WIN = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rco1,
    input  logic       rco2,
    input  logic [4:0] pnt1,
    input  logic [4:0] pnt2,
`ifdef SET_UNDO_EN
    input  logic       undo_set,
`endif
    output logic       rstpnt,
    output logic       mode25_15,
    output logic [2:0] sets1,
    output logic [2:0] sets2,
    output logic [3:0] set_num,
    output logic [4:0] last_pnt1,
    output logic [4:0] last_pnt2,
    output logic       match_over,
    output logic       winner,
    output logic       set_err
);
    localparam int         HW       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [2:0] TGT      = 3'(SETS_TO_WIN);
    localparam logic [3:0] LAST_SET = 4'(2 * SETS_TO_WIN - 1);
    localparam logic [HW-1:0] HOLD_INIT = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {PLAY, SET_END, MATCH_END} state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          rco1_q, rco2_q;
    logic          last_team;
    logic          rise1, rise2, undo;

    assign rise1     = rco1 & ~rco1_q;
    assign rise2     = rco2 & ~rco2_q;
    assign mode25_15 = (set_num != LAST_SET);

`ifdef SET_UNDO_EN
    assign undo = undo_set;
`else
    assign undo = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= PLAY;
            hold_cnt   <= '0;
            // Edge registers start high so a flag already set at reset release is not an award.
            rco1_q     <= 1'b1;
            rco2_q     <= 1'b1;
            last_team  <= 1'b0;
            rstpnt     <= 1'b0;
            sets1      <= '0;
            sets2      <= '0;
            set_num    <= 4'd1;
            last_pnt1  <= '0;
            last_pnt2  <= '0;
            match_over <= 1'b0;
            winner     <= 1'b0;
            set_err    <= 1'b0;
        end else begin
            rco1_q  <= rco1;
            rco2_q  <= rco2;
            rstpnt  <= 1'b0;
            set_err <= 1'b0;
            case (state)
                PLAY: begin
                    if (rise1 && !rise2) begin
                        sets1     <= sets1 + 3'd1;
                        last_pnt1 <= pnt1;
                        last_pnt2 <= pnt2;
                        hold_cnt  <= HOLD_INIT;
                        last_team <= 1'b0;
                        if (sets1 + 3'd1 == TGT) begin
                            state      <= MATCH_END;
                            match_over <= 1'b1;
                            winner     <= 1'b0;
                        end else begin
                            state <= SET_END;
                        end
                    end else if (rise2 && !rise1) begin
                        sets2     <= sets2 + 3'd1;
                        last_pnt1 <= pnt1;
                        last_pnt2 <= pnt2;
                        hold_cnt  <= HOLD_INIT;
                        last_team <= 1'b1;
                        if (sets2 + 3'd1 == TGT) begin
                            state      <= MATCH_END;
                            match_over <= 1'b1;
                            winner     <= 1'b1;
                        end else begin
                            state <= SET_END;
                        end
                    end else if (rise1 && rise2) begin
                        set_err <= 1'b1;
                    end
                end
                SET_END: begin
                    if (undo) begin
                        if (last_team) sets2 <= sets2 - 3'd1;
                        else           sets1 <= sets1 - 3'd1;
                        match_over <= 1'b0;
                        state      <= PLAY;
                    end else if (hold_cnt == '0) begin
                        rstpnt  <= 1'b1;
                        set_num <= set_num + 4'd1;
                        state   <= PLAY;
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                MATCH_END: begin
                    if (undo) begin
                        if (last_team) sets2 <= sets2 - 3'd1;
                        else           sets1 <= sets1 - 3'd1;
                        match_over <= 1'b0;
                        state      <= PLAY;
                    end
                end
                default: state <= PLAY;
            endcase
        end
    end
endmodule
